// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the uart_stream_bridge block.
//   - simple_uart register addresses (ODR, IDR, BSR, SR)
//   - status register bit positions
//   - bridge FSM state encoding
package uart_bridge_pkg;

  // simple_uart register map
  localparam logic [1:0] UART_ODR = 2'd0;  // output (TX) data register
  localparam logic [1:0] UART_IDR = 2'd1;  // input (RX) data register
  localparam logic [1:0] UART_BSR = 2'd2;  // baud divisor register
  localparam logic [1:0] UART_SR  = 2'd3;  // status register

  // Status register bit indices
  localparam int unsigned SR_TXBUSY = 0;
  localparam int unsigned SR_RX     = 1;
  localparam int unsigned SR_FE     = 2;

  // One UART access (or none) per state
  typedef enum logic [2:0] {
    CFG,     // write baud divisor
    GAP,     // idle, lets the UART busy bit settle
    RD_SR,   // read status
    EV_SR,   // evaluate status read data
    RD_IDR,  // read received byte
    EV_IDR,  // capture received byte into the RX buffer
    CLR,     // clear rx/fe flags
    WR_ODR   // write TX byte, pop TX FIFO
  } bridge_state_e;

endpackage

// File: rtl/uart_bridge_fifo.sv
// Register-based synchronous FIFO used for the bridge TX and RX buffers.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   push_i, wdata_i     write strobe and data (ignored when full)
//   pop_i               read strobe (ignored when empty)
//   rdata_o             head entry
//   full_o, empty_o     status
//   level_o             occupancy, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_bridge_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Gating on pre-cycle status means a push on a full FIFO is refused even
  // if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which entries
  // are meaningful, and leaving the array out of reset keeps it plain registers.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Bridge between CPU-side byte streams and the simple_uart register port.
// After reset it writes the baud divisor, then polls the UART status
// register: received bytes (with frame-error flag) are moved into an RX
// buffer and the UART flags cleared; queued TX bytes are written to ODR
// whenever the transmitter is idle. RX has priority over TX.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   tx_data_i/tx_valid_i/tx_ready_o   TX byte stream in
//   tx_level_o                        TX FIFO occupancy
//   rx_data_o/rx_fe_o/rx_valid_o/rx_ready_i   RX byte stream out
//   u_sel_o/u_addr_o/u_data_o/u_we_o  simple_uart register access (1-cycle pulses)
//   u_data_i                          simple_uart read data, valid one cycle after a read
// Build option: UART_BRIDGE_RXFIFO_EN selects an RX_DEPTH-entry RX FIFO;
// without it the RX buffer is a single holding register.
module uart_stream_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 4,
  parameter logic [9:0]  BAUD_DIV = 10'd2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic [$clog2(TX_DEPTH):0]   tx_level_o,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_fe_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic                        u_sel_o,
  output logic [1:0]                  u_addr_o,
  output logic [31:0]                 u_data_o,
  output logic                        u_we_o,
  input  logic [31:0]                 u_data_i
);

  bridge_state_e state_q, state_d;
  logic          cfg_arm_q, cfg_arm_d;  // first post-reset cycle keeps the bus quiet
  logic          fe_q, fe_d;            // frame-error flag latched at EV_SR

  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]    tx_head;
  logic          rx_full, rx_push, rx_pop;
  logic [8:0]    rx_head, rx_wdata;

  // Only the low byte and the SR flag bits of the read data are used.
  logic          unused_u_data_hi;
  assign unused_u_data_hi = ^u_data_i[31:8];

  // ---------------------------------------------------------------- TX FIFO
  assign tx_ready_o = !tx_full;
  assign tx_push    = tx_valid_i && tx_ready_o;
  assign tx_pop     = (state_q == WR_ODR);

  uart_bridge_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push),
    .wdata_i (tx_data_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level_o)
  );

  // -------------------------------------------------------------- RX buffer
  assign rx_push  = (state_q == EV_IDR);
  assign rx_wdata = {fe_q, u_data_i[7:0]};
  assign rx_pop   = rx_valid_o && rx_ready_i;

`ifdef UART_BRIDGE_RXFIFO_EN
  logic                        rx_empty;
  logic [$clog2(RX_DEPTH):0]   unused_rx_level;

  uart_bridge_fifo #(
    .WIDTH (9),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .wdata_i (rx_wdata),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (unused_rx_level)
  );

  assign rx_valid_o = !rx_empty;
`else
  localparam int unsigned unused_rx_depth = RX_DEPTH;

  logic [8:0] rx_hold_q, rx_hold_d;
  logic       rx_vld_q, rx_vld_d;

  // A pop cannot coincide with a push: the push only happens when the
  // register was already empty at EV_SR.
  always_comb begin
    rx_hold_d = rx_hold_q;
    rx_vld_d  = rx_vld_q;
    if (rx_push) begin
      rx_hold_d = rx_wdata;
      rx_vld_d  = 1'b1;
    end else if (rx_pop) begin
      rx_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_hold_q <= '0;
      rx_vld_q  <= 1'b0;
    end else begin
      rx_hold_q <= rx_hold_d;
      rx_vld_q  <= rx_vld_d;
    end
  end

  assign rx_head    = rx_hold_q;
  assign rx_full    = rx_vld_q;
  assign rx_valid_o = rx_vld_q;
`endif

  // Stale FIFO storage never reaches the outputs while the buffer is empty.
  assign rx_data_o = rx_valid_o ? rx_head[7:0] : 8'h00;
  assign rx_fe_o   = rx_valid_o ? rx_head[8]   : 1'b0;

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CFG;
      cfg_arm_q <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_arm_q <= cfg_arm_d;
      fe_q      <= fe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_arm_d = cfg_arm_q;
    fe_d      = fe_q;
    u_sel_o   = 1'b0;
    u_addr_o  = 2'd0;
    u_data_o  = 32'd0;
    u_we_o    = 1'b0;

    unique case (state_q)
      CFG: begin
        // Held one cycle after reset release so the bus is idle during reset.
        cfg_arm_d = 1'b1;
        if (cfg_arm_q) begin
          u_sel_o  = 1'b1;
          u_we_o   = 1'b1;
          u_addr_o = UART_BSR;
          u_data_o = {22'd0, BAUD_DIV};
          state_d  = GAP;
        end
      end
      GAP: begin
        state_d = RD_SR;
      end
      RD_SR: begin
        u_sel_o  = 1'b1;
        u_addr_o = UART_SR;
        state_d  = EV_SR;
      end
      EV_SR: begin
        if (u_data_i[SR_RX] && !rx_full) begin
          fe_d    = u_data_i[SR_FE];
          state_d = RD_IDR;
        end else if (!u_data_i[SR_TXBUSY] && !tx_empty) begin
          state_d = WR_ODR;
        end else begin
          state_d = GAP;
        end
      end
      RD_IDR: begin
        u_sel_o  = 1'b1;
        u_addr_o = UART_IDR;
        state_d  = EV_IDR;
      end
      EV_IDR: begin
        state_d = CLR;
      end
      CLR: begin
        u_sel_o  = 1'b1;
        u_we_o   = 1'b1;
        u_addr_o = UART_SR;
        state_d  = GAP;
      end
      WR_ODR: begin
        u_sel_o  = 1'b1;
        u_we_o   = 1'b1;
        u_addr_o = UART_ODR;
        u_data_o = {24'd0, tx_head};
        state_d  = GAP;
      end
      default: begin
        state_d = CFG;
      end
    endcase
  end

endmodule
